// File: rtl/sram_burst_pkg.sv
// Shared definitions for the SRAM burst master: FSM state encoding,
// default datapath widths and the read skid FIFO depth.
package sram_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  localparam int DEF_DW     = 64;
  localparam int DEF_MW     = DEF_DW / 8;
  localparam int DEF_AW     = 12;
  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/sram_rd_skid.sv
// Two-entry FIFO holding read words as {last, data} on their way from the
// SRAM to the read stream. A push and a pop in the same cycle leave the
// count unchanged and keep the order.
module sram_rd_skid
  import sram_burst_pkg::*;
#(
  parameter int W = DEF_DW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_cnt,
  output logic         o_valid
);

  logic [W-1:0] r_mem [FIFO_DEPTH];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign o_valid = (r_cnt != 2'd0);
  assign o_cnt   = r_cnt;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop & o_valid;
  assign w_push  = i_push & ((r_cnt != 2'(FIFO_DEPTH)) | w_pop);

  // Storage, pointers and occupancy count; reset flushes everything to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= {W{1'b0}};
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/sram_burst_master.sv
// Burst initiator for a single-port, 1-cycle-latency, byte-maskable SRAM.
// Accepts one read or write burst, issues one SRAM access per cycle and
// returns read data through a 2-entry skid FIFO.
// Optional feature macro: SRAM_BURST_WSTRB_EN adds the wr_strb port and uses
// it as the byte write mask; without it, writes update whole words.
module sram_burst_master
  import sram_burst_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int MW = DEF_MW,
  parameter int AW = DEF_AW,
  parameter int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
`ifdef SRAM_BURST_WSTRB_EN
  input  logic [MW-1:0] wr_strb,
`endif
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          done,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [MW-1:0] sram_wem,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout
);

  localparam logic [2:0] LP_DEPTH = 3'(FIFO_DEPTH);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_rem;
  logic          r_rd_pend;
  logic          r_rd_pend_last;
  logic          r_done;
  logic          w_accept;
  logic          w_wr_issue;
  logic          w_rd_issue;
  logic          w_pop;
  logic          w_done_set;
  logic [2:0]    w_occ;
  logic [1:0]    w_fifo_cnt;
  logic          w_fifo_valid;
  logic [DW:0]   w_head;
  logic [MW-1:0] w_wem_wr;

  assign cmd_ready  = (r_state == ST_IDLE);
  assign wr_ready   = (r_state == ST_WR);
  assign w_accept   = cmd_valid & cmd_ready;
  assign w_wr_issue = wr_ready & wr_valid;
  assign w_pop      = w_fifo_valid & rd_ready;
  // Words already buffered or in flight after this cycle's pop; a new read
  // may only go out while that leaves room in the FIFO.
  assign w_occ      = {1'b0, w_fifo_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
  assign w_rd_issue = (r_state == ST_RD) && (r_rem != {LW{1'b0}}) && (w_occ < LP_DEPTH);

`ifdef SRAM_BURST_WSTRB_EN
  assign w_wem_wr = wr_strb;
`else
  assign w_wem_wr = {MW{1'b1}};
`endif

  assign rd_valid  = w_fifo_valid;
  assign rd_data   = w_head[DW-1:0];
  assign rd_last   = w_head[DW];
  assign done      = r_done;
  assign sram_addr = r_addr;

  sram_rd_skid #(
    .W (DW + 1)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_rd_pend),
    .i_push_data ({r_rd_pend_last, sram_dout}),
    .i_pop       (rd_ready),
    .o_head      (w_head),
    .o_cnt       (w_fifo_cnt),
    .o_valid     (w_fifo_valid)
  );

  // SRAM pins: idle values except in the single cycle an access is issued.
  always_comb begin
    sram_cs  = 1'b0;
    sram_we  = 1'b0;
    sram_wem = {MW{1'b0}};
    sram_din = {DW{1'b0}};
    if (w_wr_issue) begin
      sram_cs  = 1'b1;
      sram_we  = 1'b1;
      sram_wem = w_wem_wr;
      sram_din = wr_data;
    end else if (w_rd_issue) begin
      sram_cs  = 1'b1;
    end else begin
      sram_cs  = 1'b0;
    end
  end

  // Next-state logic; completion requests the one-cycle done pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_done_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt = cmd_write ? ST_WR : ST_RD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD: begin
        if (w_pop && rd_last) begin
          w_state_nxt = ST_IDLE;
          w_done_set  = 1'b1;
        end else begin
          w_state_nxt = ST_RD;
        end
      end
      ST_WR: begin
        if (w_wr_issue && (r_rem == LW'(1))) begin
          w_state_nxt = ST_IDLE;
          w_done_set  = 1'b1;
        end else begin
          w_state_nxt = ST_WR;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Address/remaining counters, in-flight read flag and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr         <= {AW{1'b0}};
      r_rem          <= {LW{1'b0}};
      r_rd_pend      <= 1'b0;
      r_rd_pend_last <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr <= cmd_addr;
        r_rem  <= (cmd_len == {LW{1'b0}}) ? LW'(1) : cmd_len;
      end else if (w_wr_issue || w_rd_issue) begin
        r_addr <= r_addr + AW'(1);
        r_rem  <= r_rem - LW'(1);
      end
      r_rd_pend      <= w_rd_issue;
      r_rd_pend_last <= w_rd_issue & (r_rem == LW'(1));
      r_done         <= w_done_set;
    end
  end

endmodule

// File: tb/tb_sram_burst_master.sv
// Directed bench for sram_burst_master with a behavioural SRAM, a reference
// memory image and scoreboard queues for expected read words and addresses.
module tb_sram_burst_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [11:0] cmd_addr = 12'h000;
  logic [12:0] cmd_len = 13'd0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [63:0] wr_data = 64'h0;
`ifdef SRAM_BURST_WSTRB_EN
  logic [7:0]  wr_strb = 8'h00;
`endif
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [63:0] rd_data;
  logic        rd_last;
  logic        done;
  logic        sram_cs;
  logic        sram_we;
  logic [7:0]  sram_wem;
  logic [11:0] sram_addr;
  logic [63:0] sram_din;
  logic [63:0] sram_dout = 64'h0;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] mem      [4096];
  logic        mem_wr   [4096];
  logic [63:0] ref_mem  [4096];
  logic        ref_wr   [4096];
  logic [64:0] exp_q    [$];
  logic [11:0] addr_q   [$];

  sram_burst_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
`ifdef SRAM_BURST_WSTRB_EN
    .wr_strb   (wr_strb),
`endif
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .done      (done),
    .sram_cs   (sram_cs),
    .sram_we   (sram_we),
    .sram_wem  (sram_wem),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] init_val(input logic [11:0] a);
    return {32'hC0DE_F00D, 20'h00000, a};
  endfunction

  // Behavioural SRAM: byte-masked writes, read data one cycle after issue.
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) begin
        logic [63:0] w;
        w = mem_wr[sram_addr] ? mem[sram_addr] : init_val(sram_addr);
        for (int b = 0; b < 8; b++) begin
          if (sram_wem[b]) w[8*b +: 8] = sram_din[8*b +: 8];
        end
        mem[sram_addr]    <= w;
        mem_wr[sram_addr] <= 1'b1;
      end else begin
        sram_dout <= mem_wr[sram_addr] ? mem[sram_addr] : init_val(sram_addr);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_word(input logic [11:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  task automatic ref_write(input logic [11:0] a, input logic [63:0] d, input logic [7:0] m);
    logic [63:0] w;
    w = ref_word(a);
    for (int b = 0; b < 8; b++) begin
      if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    end
    ref_mem[a] = w;
    ref_wr[a]  = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"},
        {69'd0, cmd_ready, wr_ready, rd_valid, rd_last, done, sram_cs, sram_we, sram_wem, sram_addr},
        {69'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000});
    chk({tag, "_rd_data"}, {32'd0, rd_data}, 96'd0);
    chk({tag, "_sram_din"}, {32'd0, sram_din}, 96'd0);
  endtask

  // Write burst; data word i is base*(i+1). Optionally stall two cycles.
  task automatic wr_burst(input logic [11:0] a, input int n, input logic [63:0] base,
                          input bit stall, input logic [7:0] strb);
    int i;
    int k;
    logic [7:0]  exp_wem;
    logic [11:0] ea;
    logic [63:0] d;
`ifdef SRAM_BURST_WSTRB_EN
    exp_wem = strb;
    wr_strb = strb;
`else
    exp_wem = 8'hFF;
`endif
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = 13'(n);
    #1 chk("wr_cmd_ready", {95'd0, cmd_ready}, 96'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    i = 0; k = 0;
    while (i < n && k < 100) begin
      ea = a + 12'(i);
      d  = base * 64'(i + 1);
      if (stall && (k == 1 || k == 2)) begin
        wr_valid = 1'b0;
      end else begin
        wr_valid = 1'b1;
        wr_data  = d;
      end
      #1;
      chk("wr_ready", {95'd0, wr_ready}, 96'd1);
      if (wr_valid) begin
        chk("wr_issue", {10'd0, sram_cs, sram_we, sram_wem, sram_addr, sram_din},
            {10'd0, 1'b1, 1'b1, exp_wem, ea, d});
        ref_write(ea, d, exp_wem);
        i++;
      end else begin
        chk("wr_gap", {83'd0, sram_cs, sram_addr}, {83'd0, 1'b0, ea});
      end
      k++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    #1;
    chk("wr_done", {92'd0, done, cmd_ready, wr_ready, sram_cs}, {92'd0, 4'b1100});
    @(negedge clk);
    #1 chk("wr_done_once", {95'd0, done}, 96'd0);
  endtask

  // Read burst with rd_ready following pattern bit k%4 each cycle.
  task automatic rd_burst(input logic [11:0] a, input logic [12:0] len,
                          input logic [3:0] pat, input bit chk_lat);
    int n;
    int k;
    int issued;
    int popped;
    int first;
    logic [64:0] e;
    n = (len == 13'd0) ? 1 : int'(len);
    for (int i = 0; i < n; i++) begin
      logic [11:0] ai;
      ai = a + 12'(i);
      exp_q.push_back({(i == n - 1), ref_word(ai)});
      addr_q.push_back(ai);
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = len; rd_ready = 1'b0;
    #1 chk("rd_cmd_ready", {95'd0, cmd_ready}, 96'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0; issued = 0; popped = 0; first = -1;
    while (popped < n && k < 200) begin
      rd_ready = pat[k % 4];
      #1;
      chk("rd_occupancy", {95'd0, (issued - popped) <= 2}, 96'd1);
      if (sram_cs) begin
        chk("rd_issue_room", {95'd0, (issued - popped - ((rd_valid && rd_ready) ? 1 : 0)) < 2}, 96'd1);
        if (addr_q.size() > 0) begin
          chk("rd_addr", {83'd0, sram_we, sram_addr}, {83'd0, 1'b0, addr_q.pop_front()});
        end else begin
          chk("rd_extra_issue", {95'd0, sram_cs}, 96'd0);
        end
        issued++;
      end
      if (rd_valid && first < 0) first = k;
      if (rd_valid && rd_ready) begin
        e = exp_q.pop_front();
        chk("rd_word", {31'd0, rd_last, rd_data}, {31'd0, e});
        popped++;
      end
      k++;
      @(negedge clk);
    end
    chk("rd_complete", 96'(popped), 96'(n));
    if (chk_lat) chk("rd_latency", 96'(first), 96'd2);
    rd_ready = 1'b0;
    #1;
    chk("rd_done", {92'd0, done, cmd_ready, rd_valid, sram_cs}, {92'd0, 4'b1100});
    @(negedge clk);
    #1 chk("rd_done_once", {95'd0, done}, 96'd0);
    exp_q.delete();
    addr_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_wr[i] = 1'b0;
      ref_wr[i] = 1'b0;
      mem[i]    = 64'h0;
      ref_mem[i] = 64'h0;
    end
    #2;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Write 0x11..0x44 at 0x010 then read it back.
    wr_burst(12'h010, 4, 64'h11, 1'b0, 8'hFF);
    rd_burst(12'h010, 13'd4, 4'b1111, 1'b1);

    // Address wrap at the top of the array.
    rd_burst(12'hFFE, 13'd3, 4'b1111, 1'b0);

    // Read backpressure with rd_ready 1-0-0-1.
    rd_burst(12'h020, 13'd8, 4'b1001, 1'b0);

    // Write stall mid-burst, then read back.
    wr_burst(12'h030, 3, 64'h0101_0101_0101_0101, 1'b1, 8'hFF);
    rd_burst(12'h030, 13'd3, 4'b1111, 1'b0);

    // Strobe request: honoured only when the strobe port is built in.
    wr_burst(12'h100, 1, 64'hA1B2_C3D4_E5F6_0718, 1'b0, 8'h0F);
    rd_burst(12'h100, 13'd1, 4'b1111, 1'b0);

    // Zero length behaves as a single word.
    rd_burst(12'h010, 13'd0, 4'b1111, 1'b0);

    // Reset in the cycle a read word is in flight.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h010; cmd_len = 13'd4; rd_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1 chk("rst_pre_issue", {95'd0, sram_cs}, 96'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset_vals("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_reset", {94'd0, cmd_ready, rd_valid}, {94'd0, 2'b10});
    rd_ready = 1'b0;
    rd_burst(12'h011, 13'd1, 4'b1111, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_burst_master.md
# sram_burst_master

Burst initiator for the accelerator's single-port SRAM macros (4K x 64, byte-maskable, 1-cycle read latency). It accepts one read or write burst command and drives the SRAM chip-select, write-enable, byte-mask, address and data pins one word per cycle. Read data is returned on a valid/ready stream through a 2-entry skid FIFO, and write data is taken from a valid/ready stream. It sits between the feature-map/weight DMA logic and each SRAM wrapper instance.

## Interface
- DW, 64: data width, bits
- MW, 8: byte-mask width, DW/8
- AW, 12: word address width
- LW, AW+1: burst length width; lengths run 1..2^AW
---
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  AW  start word address
- cmd_len  in  LW  word count; 0 is illegal and is treated as 1
- wr_valid / wr_ready  in / out  1  write-data handshake
- wr_data  in  DW  write word
- wr_strb  in  MW  byte enables (only with SRAM_BURST_WSTRB_EN)
- rd_valid / rd_ready  out / in  1  read-data handshake
- rd_data  out  DW  read word
- rd_last  out  1  marks the final word of a read burst
- done  out  1  one-cycle pulse when the burst completes
- sram_cs, sram_we  out  1  SRAM chip select and write enable, active high
- sram_wem  out  MW  byte write mask, 1 = write the byte
- sram_addr  out  AW  SRAM word address
- sram_din  out  DW  SRAM write data
- sram_dout  in  DW  SRAM read data, valid the cycle after a read issue

## Operation
- States: IDLE, RD, WR.
  - IDLE→RD or IDLE→WR on cmd_valid&cmd_ready.
  - The command latches addr into the address register and len into the remaining counter.
- Issue: sram_cs=1 only in the issue cycle.
  - Issue cycles are the only cycles where the SRAM pins are non-idle.
  - The SRAM pins are combinational from registered state and the current handshakes.
  - Idle pin values: cs=0, we=0, wem=0, addr=current address register, din=0.
- WR:
  - wr_ready=1 throughout WR.
  - Each wr_valid beat issues: cs=1, we=1, wem=wr_strb, din=wr_data.
  - Each beat increments the address and decrements the remaining counter.
  - The beat with remaining==1 moves to IDLE and pulses done in the next cycle.
- RD:
  - A read issues (cs=1, we=0) when remaining>0 and fifo_cnt + rd_pend − pop < 2.
  - pop = rd_valid & rd_ready.
  - rd_pend is a flop set by the issue. The following cycle, sram_dout is pushed into the FIFO, tagged last if it was the final issue.
  - The FSM returns to IDLE, and done pulses, in the cycle after the last-tagged word pops.
- Address arithmetic: increments modulo 2^AW. 0xFFF+1 wraps to 0x000 without error.
- Simultaneous push and pop in one cycle: count is unchanged and order is preserved.
- rd_valid = FIFO non-empty. The head is held stable while rd_ready=0.
- Reset, including mid-burst:
  - FSM to IDLE; FIFO and rd_pend flushed.
  - An in-flight read word is discarded; SRAM contents are untouched.
  - Output reset values: cmd_ready=1, wr_ready=0, rd_valid=0, rd_last=0, rd_data=0, done=0, sram_cs=0, sram_we=0, sram_wem=0, sram_addr=0, sram_din=0.

## Timing
- Write throughput: 1 word per cycle while wr_valid stays high.
- Read throughput: 1 word per cycle with rd_ready held high.
  - Latency from command accept to first rd_valid: 2 cycles (issue at +0 after accept edge, push at +1, visible at +2).
- Backpressure: at most 2 words are buffered or in flight, so no word is ever dropped.
- done: one cycle, always exactly one per accepted command.
- cmd_ready returns to 1 in the same cycle done is high.

## Configuration
- SRAM_BURST_WSTRB_EN defined: the wr_strb port exists and sram_wem=wr_strb on write issues.
- SRAM_BURST_WSTRB_EN undefined: no wr_strb port; sram_wem={MW{1'b1}} on write issues and 0 otherwise.

## Structure
- Shared package sram_burst_pkg holds:
  - the state enum (IDLE, RD, WR);
  - the default DW/MW/AW constants;
  - FIFO_DEPTH=2.
- Sub-module sram_rd_skid: 2-entry FIFO carrying {last, data}, with push/pop/count.

## Test plan
- Write then read, addr=0x010, len=4, data 0x11..0x44:
  - four write cycles with wem=0xFF on addresses 0x010..0x013, then done;
  - the read returns 0x11,0x22,0x33,0x44, rd_last only on 0x44.
- Wrap: read addr=0xFFE, len=3 → sram_addr sequence 0xFFE,0xFFF,0x000.
- Backpressure: read len=8 with rd_ready toggling 1-0-0-1 →
  - the data sequence is intact;
  - fifo_cnt + rd_pend never exceeds 2;
  - no cs while both FIFO slots are occupied.
- Write stall: len=3 with wr_valid low for 2 cycles mid-burst → no cs in the gap and address unchanged.
- Strobe (with SRAM_BURST_WSTRB_EN): wr_strb=0x0F → sram_wem=0x0F.
- Without SRAM_BURST_WSTRB_EN: sram_wem=0xFF.
- Reset: assert rst_n=0 in the middle of a read, on the cycle with rd_pend=1 →
  - all outputs are at their reset values immediately;
  - after release, cmd_ready=1 and rd_valid=0;
  - a new len=1 read completes normally.
